// File: rtl/pu_send_pkg.sv
// Shared types and constants for the PU SEND instruction engine.
package pu_send_pkg;

   localparam int unsigned WORD_W       = 16;
   localparam int unsigned DM_AW_DEF    = 8;
   localparam int unsigned PORT_NUM_DEF = 4;
   localparam int unsigned PW           = $clog2(PORT_NUM_DEF);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      CAPT,
      XMIT,
      DONE
   } send_st_t;

endpackage

// File: rtl/pu_send_engine.sv
// SEND engine: reads a block of DMEM words and streams them as a valid/ready packet to a PU port.
// Optional build macro SEND_PORT_CHECK_EN rejects out-of-range destination ports with an err pulse.
module pu_send_engine
   import pu_send_pkg::*;
#(
   parameter  int unsigned DM_AW    = DM_AW_DEF,
   parameter  int unsigned PORT_NUM = PORT_NUM_DEF,
   localparam int unsigned PTW      = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              send,
   input  logic [15:0]       send_addr,
   input  logic [15:0]       send_size,
   input  logic [3:0]        send_port,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              dm_rd_en,
   output logic [DM_AW-1:0]  dm_rd_addr,
   input  logic [15:0]       dm_rd_data,
   output logic              tx_valid,
   output logic [15:0]       tx_data,
   output logic [PTW-1:0]    tx_port,
   output logic              tx_last,
   input  logic              tx_ready
);

   send_st_t          state_q, state_d;
   logic [DM_AW-1:0]  base_q, base_d;
   logic [DM_AW-1:0]  idx_q, idx_d;
   logic [WORD_W-1:0] rem_q, rem_d;
   logic [PTW-1:0]    port_d;
   logic [15:0]       data_d;
   logic              busy_d, done_d, err_d, rd_en_d, valid_d, last_d;
   logic [DM_AW-1:0]  rd_addr_d;
   logic              port_ok_c;
   logic              accept_c;

   // Upper address/port bits are architecturally ignored.
   logic unused_bits;
   assign unused_bits = ^{send_addr, send_port};

`ifdef SEND_PORT_CHECK_EN
   assign port_ok_c = (32'(send_port) < PORT_NUM);
`else
   assign port_ok_c = 1'b1;
`endif

   assign accept_c = send && port_ok_c;

   // State, counters and all outputs are registered from their next values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         base_q     <= '0;
         idx_q      <= '0;
         rem_q      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         dm_rd_en   <= 1'b0;
         dm_rd_addr <= '0;
         tx_valid   <= 1'b0;
         tx_data    <= '0;
         tx_port    <= '0;
         tx_last    <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         idx_q      <= idx_d;
         rem_q      <= rem_d;
         busy       <= busy_d;
         done       <= done_d;
         err        <= err_d;
         dm_rd_en   <= rd_en_d;
         dm_rd_addr <= rd_addr_d;
         tx_valid   <= valid_d;
         tx_data    <= data_d;
         tx_port    <= port_d;
         tx_last    <= last_d;
      end
   end

   // Next-state and next-output logic; tx_data doubles as the captured word register.
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      idx_d   = idx_q;
      rem_d   = rem_q;
      port_d  = tx_port;
      data_d  = tx_data;
      err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept_c) begin
               base_d  = send_addr[DM_AW-1:0];
               rem_d   = send_size;
               port_d  = PTW'(send_port);
               idx_d   = '0;
               state_d = (send_size == 16'd0) ? DONE : FETCH;
            end
            err_d = send && !port_ok_c;
         end
         FETCH: state_d = CAPT;
         CAPT: begin
            data_d  = dm_rd_data;
            state_d = XMIT;
         end
         XMIT: begin
            if (tx_ready) begin
               if (rem_q == 16'd1) begin
                  state_d = DONE;
               end else begin
                  rem_d   = rem_q - 16'd1;
                  idx_d   = idx_q + DM_AW'(1);
                  state_d = FETCH;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d    = (state_d != IDLE);
      done_d    = (state_d == DONE);
      rd_en_d   = (state_d == FETCH);
      rd_addr_d = rd_en_d ? DM_AW'(base_d + idx_d) : '0;
      valid_d   = (state_d == XMIT);
      last_d    = valid_d && (rem_d == 16'd1);
   end

endmodule

// File: tb/tb_pu_send_engine.sv
// Scoreboard bench for pu_send_engine: DMEM model, randomized sink, directed and random SENDs.
module tb_pu_send_engine;
   import pu_send_pkg::*;

   localparam int unsigned DM_AW    = 8;
   localparam int unsigned PORT_NUM = 4;

   logic              clk = 1'b0;
   logic              rst_n, send;
   logic [15:0]       send_addr, send_size;
   logic [3:0]        send_port;
   logic              busy, done, err, dm_rd_en;
   logic [DM_AW-1:0]  dm_rd_addr;
   logic [15:0]       dm_rd_data;
   logic              tx_valid, tx_last, tx_ready;
   logic [15:0]       tx_data;
   logic [PW-1:0]     tx_port;

   logic [15:0] mem [0:255];

   typedef struct packed {
      logic [15:0]   data;
      logic [PW-1:0] port;
      logic          last;
   } beat_t;

   beat_t            exp_q[$];
   logic [DM_AW-1:0] addr_q[$];

   int vectors = 0, miscompares = 0;
   int stall_cnt = 0, beat_cnt = 0, stall_req = 0;
   bit rand_ready = 1'b0;

   pu_send_engine #(.DM_AW(DM_AW), .PORT_NUM(PORT_NUM)) dut (
      .clk(clk), .rst_n(rst_n), .send(send), .send_addr(send_addr),
      .send_size(send_size), .send_port(send_port), .busy(busy), .done(done),
      .err(err), .dm_rd_en(dm_rd_en), .dm_rd_addr(dm_rd_addr),
      .dm_rd_data(dm_rd_data), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_port(tx_port), .tx_last(tx_last), .tx_ready(tx_ready)
   );

   always #5 clk = ~clk;

   // Synchronous-read data memory: data appears the cycle after the request.
   always @(posedge clk) if (dm_rd_en) dm_rd_data <= mem[dm_rd_addr];

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void fail(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: event not expected at %0t", name, $time);
   endfunction

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   // Sink: forced stalls first, then random or always-ready acceptance.
   initial tx_ready = 1'b0;
   always begin
      @(posedge clk);
      #1;
      if (stall_req > 0 && tx_valid) begin
         tx_ready  = 1'b0;
         stall_req = stall_req - 1;
      end else if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
      else tx_ready = 1'b1;
   end

   // Monitor: checks reads and accepted beats against the scoreboard, and hold-while-stalled.
   logic        prev_hold = 1'b0;
   logic [31:0] prev_v = '0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_hold)
            check("tx_hold", 32'({tx_valid, tx_last, tx_port, tx_data}), prev_v);
         if (dm_rd_en) begin
            if (addr_q.size() == 0) fail("spurious_read");
            else check("rd_addr", 32'(dm_rd_addr), 32'(addr_q.pop_front()));
         end
         if (tx_valid && !tx_ready) stall_cnt++;
         if (tx_valid && tx_ready) begin
            beat_cnt++;
            if (exp_q.size() == 0) fail("spurious_beat");
            else begin
               beat_t e;
               e = exp_q.pop_front();
               check("tx_data", 32'(tx_data), 32'(e.data));
               check("tx_port", 32'(tx_port), 32'(e.port));
               check("tx_last", 32'(tx_last), 32'(e.last));
            end
         end
         prev_hold = tx_valid && !tx_ready;
         prev_v    = 32'({tx_valid, tx_last, tx_port, tx_data});
      end else begin
         prev_hold = 1'b0;
      end
   end

   function automatic bit port_accepted(input logic [3:0] p);
`ifdef SEND_PORT_CHECK_EN
      return int'(p) < int'(PORT_NUM);
`else
      return 1'b1;
`endif
   endfunction

   // Queue the words a SEND should produce: consecutive addresses wrapping at the DMEM size.
   task automatic expect_packet(input logic [15:0] a, input logic [15:0] s, input logic [3:0] p);
      for (int i = 0; i < int'(s); i++) begin
         int    ad;
         beat_t b;
         ad     = (int'(a) + i) % (1 << DM_AW);
         b.data = mem[ad];
         b.port = PW'(int'(p) % int'(PORT_NUM));
         b.last = (i == int'(s) - 1);
         addr_q.push_back(DM_AW'(ad));
         exp_q.push_back(b);
      end
   endtask

   task automatic issue(input logic [15:0] a, input logic [15:0] s, input logic [3:0] p);
      send = 1'b1; send_addr = a; send_size = s; send_port = p;
      cyc();
      send = 1'b0; send_addr = $urandom; send_size = $urandom; send_port = $urandom;
   endtask

   task automatic run_send(input logic [15:0] a, input logic [15:0] s, input logic [3:0] p,
                           input int stalls);
      int done_cyc, budget;
      bit busy_ok;
      stall_cnt = 0; beat_cnt = 0; stall_req = stalls;
      if (!port_accepted(p)) begin
         issue(a, s, p);
         check("err_pulse", 32'({err, busy}), 32'h2);
         cyc();
         check("err_clear", 32'({err, busy, done}), 32'h0);
         return;
      end
      expect_packet(a, s, p);
      issue(a, s, p);
      done_cyc = 0; busy_ok = 1'b1;
      budget   = 12 * int'(s) + stalls + 50;
      for (int c = 1; c <= budget; c++) begin
         if (!busy) busy_ok = 1'b0;
         if (done) begin done_cyc = c; break; end
         cyc();
      end
      if (done_cyc == 0) fail("done_timeout");
      else check("done_cycle", 32'(done_cyc), 32'(3 * int'(s) + 1 + stall_cnt));
      check("busy_span", 32'(busy_ok), 32'h1);
      if (stalls > 0 && !rand_ready) check("stall_count", 32'(stall_cnt), 32'(stalls));
      cyc();
      check("post_done", 32'({busy, done}), 32'h0);
      check("queues_empty", 32'(exp_q.size() + addr_q.size()), 32'h0);
      exp_q.delete(); addr_q.delete();
   endtask

   initial begin
      bit found;
      rst_n = 1'b0; send = 1'b0; send_addr = '0; send_size = '0; send_port = '0;
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      repeat (3) cyc();
      check("reset_outputs", 32'({busy, done, err, dm_rd_en, tx_valid, tx_last, tx_port,
                                  dm_rd_addr, tx_data}), 32'h0);
      rst_n = 1'b1;
      cyc();

      mem[10] = 16'h00A1; mem[11] = 16'h00B2; mem[12] = 16'h00C3;
      run_send(16'd10, 16'd3, 4'd2, 0);
      run_send(16'h1234, 16'd0, 4'd1, 0);
      run_send(16'd40, 16'd2, 4'd1, 5);
      run_send(16'h00FF, 16'd2, 4'd3, 0);
      run_send(16'h0020, 16'd2, 4'd7, 0);

      // Abort a packet with reset while its second beat is on the bus.
      stall_cnt = 0; beat_cnt = 0; stall_req = 0;
      expect_packet(16'd100, 16'd3, 4'd0);
      issue(16'd100, 16'd3, 4'd0);
      found = 1'b0;
      for (int c = 0; c < 30; c++) begin
         if (tx_valid && beat_cnt == 2) begin found = 1'b1; break; end
         cyc();
      end
      if (!found) fail("rst_setup_timeout");
      rst_n = 1'b0;
      cyc();
      check("mid_reset_outputs", 32'({busy, done, err, dm_rd_en, tx_valid, tx_last, tx_port,
                                      dm_rd_addr, tx_data}), 32'h0);
      exp_q.delete(); addr_q.delete();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         cyc();
         check("post_reset_idle", 32'({busy, done, tx_valid}), 32'h0);
      end
      run_send(16'd200, 16'd2, 4'd1, 0);

      rand_ready = 1'b1;
      for (int t = 0; t < 40; t++) begin
         logic [15:0] a, s;
         logic [3:0]  p;
         a = 16'($urandom);
         s = 16'($urandom_range(0, 6));
         p = 4'($urandom_range(0, 15));
         run_send(a, s, p, 0);
         repeat ($urandom_range(0, 2)) cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
